// File: rtl/corner_tracker.sv
// Tracks the four extreme foreground points of a raster binary mask and smooths them
// over a power-of-two frame history, falling back to full-frame corners after repeated misses.
module corner_tracker #(
    parameter int H_RES    = 800,
    parameter int V_RES    = 600,
    parameter int COL_W    = 10,
    parameter int ROW_W    = 10,
    parameter int AVG_LOG2 = 2,
    parameter int MIN_PIX  = 255,
    parameter int MISS_MAX = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    input  logic                   i_data,
    input  logic                   i_sof,
    output logic                   o_valid,
    output logic                   o_success,
    output logic [((MISS_MAX > 0) ? $clog2(MISS_MAX + 1) : 1)-1:0] o_miss_cnt,
    output logic [ROW_W+COL_W-1:0] o_ul_addr,
    output logic [ROW_W+COL_W-1:0] o_ur_addr,
    output logic [ROW_W+COL_W-1:0] o_dl_addr,
    output logic [ROW_W+COL_W-1:0] o_dr_addr
);
    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int MISS_W = (MISS_MAX > 0) ? $clog2(MISS_MAX + 1) : 1;
    localparam int CNT_W  = (MIN_PIX > 1) ? $clog2(MIN_PIX + 1) : 1;
    localparam int SUM_RW = ROW_W + AVG_LOG2;
    localparam int SUM_CW = COL_W + AVG_LOG2;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(H_RES - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(V_RES - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(MIN_PIX);
    localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MISS_MAX);

    // Corner slots: 0 = UL (top-most), 1 = UR (right-most), 2 = DL (left-most), 3 = DR (bottom-most)
    function automatic logic [ROW_W-1:0] def_row(input int k);
        return (k >= 2) ? ROW_LAST : '0;
    endfunction

    function automatic logic [COL_W-1:0] def_col(input int k);
        return (k % 2 == 1) ? COL_LAST : '0;
    endfunction

    logic [COL_W-1:0]  col_reg, col_next, pix_col;
    logic [ROW_W-1:0]  row_reg, row_next, pix_row;
    logic [CNT_W-1:0]  cnt_reg, cnt_base, cnt_next;
    logic [ROW_W-1:0]  ext_row_reg [4];
    logic [ROW_W-1:0]  ext_row_next [4];
    logic [COL_W-1:0]  ext_col_reg [4];
    logic [COL_W-1:0]  ext_col_next [4];
    logic [MISS_W-1:0] miss_reg;
    logic              at_origin, eof, hit, flush;
    logic [ROW_W-1:0]  hist_row [DEPTH][4];
    logic [COL_W-1:0]  hist_col [DEPTH][4];
    logic [ROW_W-1:0]  avg_row [4];
    logic [COL_W-1:0]  avg_col [4];

    always_comb begin
        pix_col   = i_sof ? '0 : col_reg;
        pix_row   = i_sof ? '0 : row_reg;
        at_origin = (pix_col == '0) && (pix_row == '0);
        eof       = i_valid && (pix_col == COL_LAST) && (pix_row == ROW_LAST);
        col_next  = (pix_col == COL_LAST) ? '0 : pix_col + COL_W'(1);
        row_next  = pix_row;
        if (pix_col == COL_LAST)
            row_next = (pix_row == ROW_LAST) ? '0 : pix_row + ROW_W'(1);

        // Accumulators restart at the frame origin before that pixel is scored
        cnt_base     = at_origin ? '0 : cnt_reg;
        cnt_next     = cnt_base;
        ext_row_next = ext_row_reg;
        ext_col_next = ext_col_reg;
        if (i_data) begin
            if (cnt_base != CNT_FULL)
                cnt_next = cnt_base + CNT_W'(1);
            if (cnt_base == '0) begin
                for (int k = 0; k < 4; k++) begin
                    ext_row_next[k] = pix_row;
                    ext_col_next[k] = pix_col;
                end
            end else begin
                if (pix_row < ext_row_reg[0]) begin
                    ext_row_next[0] = pix_row;
                    ext_col_next[0] = pix_col;
                end
                if (pix_col > ext_col_reg[1]) begin
                    ext_row_next[1] = pix_row;
                    ext_col_next[1] = pix_col;
                end
                if (pix_col <= ext_col_reg[2]) begin
                    ext_row_next[2] = pix_row;
                    ext_col_next[2] = pix_col;
                end
                if (pix_row >= ext_row_reg[3]) begin
                    ext_row_next[3] = pix_row;
                    ext_col_next[3] = pix_col;
                end
            end
        end
        hit   = (cnt_next == CNT_FULL);
        flush = !hit && (miss_reg == MISS_LIM);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_reg <= '0;
            row_reg <= '0;
            cnt_reg <= '0;
            for (int k = 0; k < 4; k++) begin
                ext_row_reg[k] <= '0;
                ext_col_reg[k] <= '0;
            end
        end else if (i_valid) begin
            col_reg     <= col_next;
            row_reg     <= row_next;
            cnt_reg     <= cnt_next;
            ext_row_reg <= ext_row_next;
            ext_col_reg <= ext_col_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid   <= 1'b0;
            o_success <= 1'b0;
            miss_reg  <= '0;
        end else begin
            o_valid <= eof;
            if (eof) begin
                if (hit) begin
                    miss_reg  <= '0;
                    o_success <= 1'b1;
                end else if (!flush) begin
                    miss_reg <= miss_reg + MISS_W'(1);
                end else begin
                    miss_reg  <= '0;
                    o_success <= 1'b0;
                end
            end
        end
    end

    // A miss re-inserts the newest entry so the average keeps its weighting
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                for (int k = 0; k < 4; k++) begin
                    hist_row[e][k] <= def_row(k);
                    hist_col[e][k] <= def_col(k);
                end
            end
        end else if (eof) begin
            for (int e = DEPTH - 1; e >= 1; e--) begin
                for (int k = 0; k < 4; k++) begin
                    hist_row[e][k] <= flush ? def_row(k) : hist_row[e-1][k];
                    hist_col[e][k] <= flush ? def_col(k) : hist_col[e-1][k];
                end
            end
            for (int k = 0; k < 4; k++) begin
                hist_row[0][k] <= flush ? def_row(k) : (hit ? ext_row_next[k] : hist_row[0][k]);
                hist_col[0][k] <= flush ? def_col(k) : (hit ? ext_col_next[k] : hist_col[0][k]);
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_avg
        logic [SUM_RW-1:0] sum_row;
        logic [SUM_CW-1:0] sum_col;
        always_comb begin
            sum_row = '0;
            sum_col = '0;
            for (int e = 0; e < DEPTH; e++) begin
                sum_row = sum_row + SUM_RW'(hist_row[e][gi]);
                sum_col = sum_col + SUM_CW'(hist_col[e][gi]);
            end
        end
        assign avg_row[gi] = ROW_W'(sum_row >> AVG_LOG2);
        assign avg_col[gi] = COL_W'(sum_col >> AVG_LOG2);
    end

    assign o_miss_cnt = miss_reg;
    assign o_ul_addr  = {avg_row[0], avg_col[0]};
    assign o_ur_addr  = {avg_row[1], avg_col[1]};
    assign o_dl_addr  = {avg_row[2], avg_col[2]};
    assign o_dr_addr  = {avg_row[3], avg_col[3]};

endmodule

// File: tb/tb_corner_tracker.sv
// Drives random and directed mask frames into two corner_tracker instances (no averaging and
// 2-frame averaging) and compares them with a frame-level reference model.
`timescale 1ns/1ps
module tb_corner_tracker;
    localparam int H     = 8;
    localparam int V     = 6;
    localparam int CW    = 10;
    localparam int RW    = 10;
    localparam int MINP  = 2;
    localparam int MISSM = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic vld   = 1'b0;
    logic dat   = 1'b0;
    logic sof   = 1'b0;

    logic ov0, ov1, os0, os1;
    logic [0:0] om0, om1;
    logic [RW+CW-1:0] ul0, ur0, dl0, dr0, ul1, ur1, dl1, dr1;
    logic [RW+CW-1:0] addr_o [2][4];
    logic ov_a [2];
    logic os_a [2];
    logic [0:0] om_a [2];

    assign addr_o[0][0] = ul0;
    assign addr_o[0][1] = ur0;
    assign addr_o[0][2] = dl0;
    assign addr_o[0][3] = dr0;
    assign addr_o[1][0] = ul1;
    assign addr_o[1][1] = ur1;
    assign addr_o[1][2] = dl1;
    assign addr_o[1][3] = dr1;
    assign ov_a[0] = ov0;
    assign ov_a[1] = ov1;
    assign os_a[0] = os0;
    assign os_a[1] = os1;
    assign om_a[0] = om0;
    assign om_a[1] = om1;

    always #5 clk = ~clk;

    corner_tracker #(.H_RES(H), .V_RES(V), .COL_W(CW), .ROW_W(RW), .AVG_LOG2(0),
                     .MIN_PIX(MINP), .MISS_MAX(MISSM)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .i_data(dat), .i_sof(sof),
        .o_valid(ov0), .o_success(os0), .o_miss_cnt(om0),
        .o_ul_addr(ul0), .o_ur_addr(ur0), .o_dl_addr(dl0), .o_dr_addr(dr0));

    corner_tracker #(.H_RES(H), .V_RES(V), .COL_W(CW), .ROW_W(RW), .AVG_LOG2(1),
                     .MIN_PIX(MINP), .MISS_MAX(MISSM)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .i_data(dat), .i_sof(sof),
        .o_valid(ov1), .o_success(os1), .o_miss_cnt(om1),
        .o_ul_addr(ul1), .o_ur_addr(ur1), .o_dl_addr(dl1), .o_dr_addr(dr1));

    // Reference model state
    int  depth_m [2] = '{1, 2};
    int  hist_r [2][2][4];
    int  hist_c [2][2][4];
    int  miss_m [2];
    bit  succ_m [2];
    int  mrow, mcol;
    bit  fmask [V][H];
    bit  stim [V][H];
    int  total = 0;
    int  bad = 0;
    int  px_count = 0;
    int  pulse_count = 0;
    int  last_pulse_px = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int def_r(input int k);
        return (k >= 2) ? V - 1 : 0;
    endfunction

    function automatic int def_c(input int k);
        return (k % 2 == 1) ? H - 1 : 0;
    endfunction

    function automatic int pack_addr(input int r, input int c);
        return (r << CW) | c;
    endfunction

    task automatic model_reset();
        mrow = 0;
        mcol = 0;
        for (int d = 0; d < 2; d++) begin
            miss_m[d] = 0;
            succ_m[d] = 1'b0;
            for (int e = 0; e < 2; e++)
                for (int k = 0; k < 4; k++) begin
                    hist_r[d][e][k] = def_r(k);
                    hist_c[d][e][k] = def_c(k);
                end
        end
    endtask

    // Extremes from whole-frame properties: U first fg, D last fg,
    // R first fg on max column, L last fg on min column
    task automatic eval_frame();
        int cnt, ur, uc, dr, dc, lr, lc, rr, rc, minc, maxc;
        int nr [4];
        int nc [4];
        cnt = 0; ur = -1; uc = 0; dr = 0; dc = 0; lr = 0; lc = 0; rr = -1; rc = 0;
        minc = H; maxc = -1;
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                if (fmask[r][c]) begin
                    cnt++;
                    if (ur < 0) begin ur = r; uc = c; end
                    dr = r; dc = c;
                    if (c < minc) minc = c;
                    if (c > maxc) maxc = c;
                end
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                if (fmask[r][c]) begin
                    if (c == maxc && rr < 0) begin rr = r; rc = c; end
                    if (c == minc) begin lr = r; lc = c; end
                end
        nr = '{ur, rr, lr, dr};
        nc = '{uc, rc, lc, dc};
        for (int d = 0; d < 2; d++) begin
            if (cnt >= MINP) begin
                for (int e = depth_m[d] - 1; e > 0; e--)
                    for (int k = 0; k < 4; k++) begin
                        hist_r[d][e][k] = hist_r[d][e-1][k];
                        hist_c[d][e][k] = hist_c[d][e-1][k];
                    end
                for (int k = 0; k < 4; k++) begin
                    hist_r[d][0][k] = nr[k];
                    hist_c[d][0][k] = nc[k];
                end
                miss_m[d] = 0;
                succ_m[d] = 1'b1;
            end else if (miss_m[d] < MISSM) begin
                for (int e = depth_m[d] - 1; e > 0; e--)
                    for (int k = 0; k < 4; k++) begin
                        hist_r[d][e][k] = hist_r[d][e-1][k];
                        hist_c[d][e][k] = hist_c[d][e-1][k];
                    end
                miss_m[d]++;
            end else begin
                for (int e = 0; e < 2; e++)
                    for (int k = 0; k < 4; k++) begin
                        hist_r[d][e][k] = def_r(k);
                        hist_c[d][e][k] = def_c(k);
                    end
                miss_m[d] = 0;
                succ_m[d] = 1'b0;
            end
        end
    endtask

    function automatic int exp_addr(input int d, input int k);
        int sr, sc;
        sr = 0;
        sc = 0;
        for (int e = 0; e < depth_m[d]; e++) begin
            sr += hist_r[d][e][k];
            sc += hist_c[d][e][k];
        end
        return pack_addr(sr / depth_m[d], sc / depth_m[d]);
    endfunction

    task automatic check_outputs(input string pre);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++)
                check_eq($sformatf("%s_dut%0d_corner%0d", pre, d, k), int'(addr_o[d][k]), exp_addr(d, k));
            check_eq($sformatf("%s_dut%0d_success", pre, d), int'(os_a[d]), int'(succ_m[d]));
            check_eq($sformatf("%s_dut%0d_miss", pre, d), int'(om_a[d]), miss_m[d]);
        end
    endtask

    // One clock: drive after a negedge, model at the posedge, check at the next negedge
    task automatic px(input bit v, input bit d, input bit s);
        bit exp_pulse;
        int pr, pc;
        exp_pulse = 1'b0;
        vld = v;
        dat = d;
        sof = s;
        @(posedge clk);
        if (v) begin
            px_count++;
            pr = s ? 0 : mrow;
            pc = s ? 0 : mcol;
            if (pr == 0 && pc == 0)
                for (int r = 0; r < V; r++)
                    for (int c = 0; c < H; c++)
                        fmask[r][c] = 1'b0;
            fmask[pr][pc] = d;
            if (pr == V - 1 && pc == H - 1) begin
                eval_frame();
                exp_pulse = 1'b1;
            end
            mcol = pc + 1;
            mrow = pr;
            if (mcol == H) begin
                mcol = 0;
                mrow = (pr + 1) % V;
            end
        end
        @(negedge clk);
        vld = 1'b0;
        dat = 1'b0;
        sof = 1'b0;
        for (int i = 0; i < 2; i++)
            check_eq($sformatf("o_valid_dut%0d", i), int'(ov_a[i]), int'(exp_pulse));
        if (ov0) begin
            pulse_count++;
            last_pulse_px = px_count;
        end
        if (exp_pulse || $urandom_range(0, 7) == 0)
            check_outputs("out");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            px(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic send_frame(input bit first_sof, input bit gaps);
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++) begin
                if (gaps && $urandom_range(0, 3) == 0)
                    idle($urandom_range(1, 3));
                px(1'b1, stim[r][c], (r == 0 && c == 0) ? first_sof : 1'b0);
            end
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++)
            px(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic clear_stim();
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                stim[r][c] = 1'b0;
    endtask

    initial begin
        int base, p0, dens;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check_eq("rst_ul", int'(ul0), pack_addr(0, 0));
        check_eq("rst_ur", int'(ur0), pack_addr(0, H - 1));
        check_eq("rst_dl", int'(dl0), pack_addr(V - 1, 0));
        check_eq("rst_dr", int'(dr0), pack_addr(V - 1, H - 1));
        check_eq("rst_success", int'(os0), 0);
        check_eq("rst_valid", int'(ov0), 0);
        check_outputs("rst");

        clear_stim();
        stim[1][3] = 1'b1; stim[2][1] = 1'b1; stim[2][6] = 1'b1; stim[4][4] = 1'b1;
        send_frame(1'b0, 1'b0);
        check_eq("fa_ul", int'(ul0), pack_addr(1, 3));
        check_eq("fa_ur", int'(ur0), pack_addr(2, 6));
        check_eq("fa_dl", int'(dl0), pack_addr(2, 1));
        check_eq("fa_dr", int'(dr0), pack_addr(4, 4));
        check_eq("fa_success", int'(os0), 1);
        idle(1);

        clear_stim();
        stim[3][2] = 1'b1; stim[3][5] = 1'b1;
        send_frame(1'b0, 1'b1);
        check_eq("tie_ul", int'(ul0), pack_addr(3, 2));
        check_eq("tie_ur", int'(ur0), pack_addr(3, 5));
        check_eq("tie_dl", int'(dl0), pack_addr(3, 2));
        check_eq("tie_dr", int'(dr0), pack_addr(3, 5));

        clear_stim();
        send_frame(1'b0, 1'b1);
        check_eq("miss1_ul", int'(ul0), pack_addr(3, 2));
        check_eq("miss1_success", int'(os0), 1);
        check_eq("miss1_cnt", int'(om0), 1);
        send_frame(1'b0, 1'b0);
        check_eq("miss2_ul", int'(ul0), pack_addr(0, 0));
        check_eq("miss2_dr", int'(dr0), pack_addr(V - 1, H - 1));
        check_eq("miss2_success", int'(os0), 0);
        check_eq("miss2_cnt", int'(om0), 0);

        clear_stim();
        stim[2][2] = 1'b1; stim[4][4] = 1'b1;
        send_frame(1'b0, 1'b1);
        clear_stim();
        stim[5][3] = 1'b1; stim[5][6] = 1'b1;
        send_frame(1'b0, 1'b1);
        check_eq("avg_ul", int'(ul1), pack_addr(3, 2));

        clear_stim();
        stim[1][1] = 1'b1; stim[4][6] = 1'b1;
        p0 = pulse_count;
        send_partial(3 * H + 4);
        base = px_count;
        send_frame(1'b1, 1'b0);
        check_eq("sof_pulses", pulse_count - p0, 1);
        check_eq("sof_latency", last_pulse_px - base, H * V);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 4))
                0: dens = 0;
                1: dens = 3;
                2: dens = 10;
                3: dens = 30;
                default: dens = 60;
            endcase
            for (int r = 0; r < V; r++)
                for (int c = 0; c < H; c++)
                    stim[r][c] = ($urandom_range(0, 99) < dens);
            if (it == 15) begin
                send_partial($urandom_range(5, 40));
                rst_n = 1'b0;
                #1;
                model_reset();
                check_eq("midrst_valid", int'(ov0), 0);
                check_outputs("midrst");
                @(negedge clk);
                rst_n = 1'b1;
            end else if ($urandom_range(0, 5) == 0) begin
                send_partial($urandom_range(1, H * V - 1));
                send_frame(1'b1, 1'b1);
            end else begin
                send_frame(1'($urandom_range(0, 1)), 1'b1);
            end
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
